// File: rtl/approx_mult_seq.sv
// Sequential DRUM-style approximate multiplier: leading-one normalise, SEG x SEG shift-add, de-normalise.
// Optional build macro APPROX_ROUND_EN forces each segment LSB to 1 when discarded bits are non-zero.
module approx_mult_seq #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int KW = $clog2(SEG + 1);
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * SEG;

`ifdef APPROX_ROUND_EN
  localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << (WIDTH - SEG)) - WIDTH'(1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NORM   = 3'd1,
    S_MULT   = 3'd2,
    S_DENORM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] na_q, na_d, nb_q, nb_d;
  logic [CW-1:0]   sa_q, sa_d, sb_q, sb_d;
  logic [SW-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [SEG-1:0]  mplier_q, mplier_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [PW-1:0]   product_q, product_d;
  logic [CW:0]     shift_s;
  logic [PW-1:0]   scaled_s;

  // Top SEG bits of a normalised operand, optionally unbiased by the bits below it.
  function automatic logic [SEG-1:0] seg_of(input logic [WIDTH-1:0] n);
    logic [SEG-1:0] s;
`ifdef APPROX_ROUND_EN
    s = n[WIDTH-1 -: SEG];
    if ((n & LOW_MASK) != {WIDTH{1'b0}}) begin
      s[0] = 1'b1;
    end else begin
      s[0] = s[0];
    end
`else
    s = n[WIDTH-1 -: SEG];
`endif
    return s;
  endfunction

  // Next-state and datapath update for the multiply sequence.
  always_comb begin
    state_d   = state_q;
    na_d      = na_q;
    nb_d      = nb_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    shift_s   = {1'b0, sa_q} + {1'b0, sb_q};
    // acc < 2^(2*SEG), so scaling back up to full width never loses bits.
    scaled_s  = PW'(acc_q) << (2 * (WIDTH - SEG));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          na_d   = a;
          nb_d   = b;
          sa_d   = {CW{1'b0}};
          sb_d   = {CW{1'b0}};
          busy_d = 1'b1;
          if ((a == {WIDTH{1'b0}}) || (b == {WIDTH{1'b0}})) begin
            product_d = {PW{1'b0}};
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_NORM;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_NORM: begin
        if (na_q[WIDTH-1] && nb_q[WIDTH-1]) begin
          mcand_d  = {{SEG{1'b0}}, seg_of(na_q)};
          mplier_d = seg_of(nb_q);
          acc_d    = {SW{1'b0}};
          cnt_d    = {KW{1'b0}};
          state_d  = S_MULT;
        end else begin
          if (!na_q[WIDTH-1]) begin
            na_d = {na_q[WIDTH-2:0], 1'b0};
            sa_d = sa_q + CW'(1);
          end else begin
            na_d = na_q;
          end
          if (!nb_q[WIDTH-1]) begin
            nb_d = {nb_q[WIDTH-2:0], 1'b0};
            sb_d = sb_q + CW'(1);
          end else begin
            nb_d = nb_q;
          end
        end
      end
      S_MULT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = {mcand_q[SW-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[SEG-1:1]};
        cnt_d    = cnt_q + KW'(1);
        if (cnt_q == KW'(SEG - 1)) begin
          state_d = S_DENORM;
        end else begin
          state_d = S_MULT;
        end
      end
      S_DENORM: begin
        product_d = scaled_s >> shift_s;
        done_d    = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      na_q      <= {WIDTH{1'b0}};
      nb_q      <= {WIDTH{1'b0}};
      sa_q      <= {CW{1'b0}};
      sb_q      <= {CW{1'b0}};
      mcand_q   <= {SW{1'b0}};
      mplier_q  <= {SEG{1'b0}};
      acc_q     <= {SW{1'b0}};
      cnt_q     <= {KW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {PW{1'b0}};
    end else begin
      state_q   <= state_d;
      na_q      <= na_d;
      nb_q      <= nb_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_approx_mult_seq.sv
// Self-checking bench for approx_mult_seq: directed cases plus random stress against a behavioural model.
module tb_approx_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [7:0]  a, b;
  logic        busy4, done4, busy8, done8;
  logic [15:0] prod4, prod8;
  int          checks = 0;
  int          errors = 0;

`ifdef APPROX_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  always #5 clk = ~clk;

  approx_mult_seq #(.WIDTH(8), .SEG(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b),
    .busy(busy4), .done(done4), .product(prod4)
  );

  approx_mult_seq #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a), .b(b),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lz8(input logic [7:0] v);
    int n = 0;
    while (n < 8 && v[7-n] == 1'b0) n++;
    return n;
  endfunction

  // DRUM rule: keep the top seg bits after the leading one, multiply, scale back.
  function automatic int ref_prod(input logic [7:0] x, input logic [7:0] y, input int seg, input bit rnd);
    int lx, ly, nx, ny, sx, sy, drop;
    if (x == 8'd0 || y == 8'd0) return 0;
    lx = lz8(x);
    ly = lz8(y);
    nx = (int'(x) << lx) & 255;
    ny = (int'(y) << ly) & 255;
    drop = 8 - seg;
    sx = nx / (1 << drop);
    sy = ny / (1 << drop);
    if (rnd && (nx % (1 << drop)) != 0) sx = sx | 1;
    if (rnd && (ny % (1 << drop)) != 0) sy = sy | 1;
    return ((sx * sy) * (1 << (2 * drop))) / (1 << (lx + ly));
  endfunction

  function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y, input int seg);
    int lx, ly;
    if (x == 8'd0 || y == 8'd0) return 0;
    lx = lz8(x);
    ly = lz8(y);
    return ((lx > ly) ? lx : ly) + seg + 2;
  endfunction

  task automatic run_op(input bit use8, input logic [7:0] ia, input logic [7:0] ib,
                        input bit hold, input string tag);
    int lat;
    bit seen, busy_ok;
    int seg;
    seg = use8 ? 8 : 4;
    @(negedge clk);
    a = ia;
    b = ib;
    if (use8) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      a = 8'($urandom);
      b = 8'($urandom);
    end else begin
      start4 = 1'b0;
      start8 = 1'b0;
    end
    lat = 0;
    seen = 1'b0;
    busy_ok = 1'b1;
    while (!seen && lat < 40) begin
      if (!(use8 ? busy8 : busy4)) busy_ok = 1'b0;
      if (use8 ? done8 : done4) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(ref_lat(ia, ib, seg)));
    check_eq({tag, "_prod"}, 32'(use8 ? prod8 : prod4), 32'(ref_prod(ia, ib, seg, RND)));
    check_eq({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(use8 ? done8 : done4), 32'd0);
    check_eq({tag, "_idle"}, 32'(use8 ? busy8 : busy4), 32'd0);
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  initial begin
    bit saw_done;
    logic [7:0] ra, rb;
    rst = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    a = 8'd0;
    b = 8'd0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy4), 32'd0);
    check_eq("rst_done", 32'(done4), 32'd0);
    check_eq("rst_prod", 32'(prod4), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 8'hFF, 8'hFF, 1'b0, "max");
    check_eq("max_const", 32'(prod4), 32'hE100);
    run_op(1'b0, 8'h0C, 8'h0A, 1'b0, "small");
    check_eq("small_const", 32'(prod4), 32'd120);
    run_op(1'b0, 8'hA7, 8'h80, 1'b0, "round");
    check_eq("round_const", 32'(prod4), RND ? 32'd22528 : 32'd20480);
    run_op(1'b0, 8'h00, 8'h5A, 1'b1, "zero");
    check_eq("zero_const", 32'(prod4), 32'd0);
    run_op(1'b0, 8'hFF, 8'h81, 1'b1, "hold");

    // Abort an operation while it is in the multiply phase.
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_busy", 32'(busy4), 32'd0);
    check_eq("mid_done", 32'(done4), 32'd0);
    check_eq("mid_prod", 32'(prod4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done4) saw_done = 1'b1;
    end
    check_eq("mid_nodone", 32'(saw_done), 32'd0);
    run_op(1'b0, 8'd3, 8'd5, 1'b0, "post_rst");
    check_eq("post_rst_const", 32'(prod4), 32'd15);

    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      run_op(1'b0, ra, rb, 1'b0, "rnd4");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom);
      run_op(1'b1, ra, rb, 1'b0, "rnd8");
      check_eq("rnd8_exact", 32'(prod8), 32'(int'(ra) * int'(rb)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
